// File: rtl/pulse_meter_pkg.sv
// rtl/pulse_meter_pkg.sv - shared state encoding and default widths for the pulse rate meter
package pulse_meter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_GATE_W = 24;

endpackage

// File: rtl/pulse_rate_meter_rise_detect.sv
// rtl/pulse_rate_meter_rise_detect.sv - registered rising-edge detector for a pulse level
module rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pulse_i,
  output logic rise_o
);

  logic pulse_q;

  // remember last cycle's level so a level held high yields a single rise
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_i;
    end
  end

  assign rise_o = pulse_i & ~pulse_q;

endmodule

// File: rtl/pulse_rate_meter.sv
// rtl/pulse_rate_meter.sv - gated rising-edge counter with a one-entry valid/ready result register
module pulse_rate_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GATE_W = DEF_GATE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse,
  input  logic              enable,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              dropped
);

  state_e              state_q, state_d;
  logic [GATE_W-1:0]   len_q, len_d;
  logic [GATE_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  logic                out_valid_q;
  logic [CNT_W-1:0]    out_count_q;
  logic                out_ovf_q;
  logic                dropped_q;

  logic                rise;
  logic                cnt_at_max;
  logic [CNT_W-1:0]    cnt_next;
  logic                ovf_next;
  logic                last_cycle;
  logic [GATE_W-1:0]   gate_len_eff;
  logic                load;

  rise_detect u_rise_detect (
    .clk_i   (clk),
    .rst_i   (reset),
    .pulse_i (pulse),
    .rise_o  (rise)
  );

  // a zero length would never reach its last cycle, so it runs as a one-cycle window
  assign gate_len_eff = (gate_len == '0) ? GATE_W'(1) : gate_len;

  // count value and overflow flag including this cycle's sample; saturates at all-ones
  assign cnt_at_max = &cnt_q;
  assign cnt_next   = (rise && !cnt_at_max) ? cnt_q + CNT_W'(1) : cnt_q;
  assign ovf_next   = ovf_q | (rise & cnt_at_max);
  assign last_cycle = (cyc_q == len_q - GATE_W'(1));

  // window sequencing: start, count, hand result over, then restart or go idle
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_COUNT;
          len_d   = gate_len_eff;
          cyc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_COUNT: begin
        if (last_cycle) begin
          load  = 1'b1;
          cyc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          if (enable) begin
            len_d = gate_len_eff;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cyc_d = cyc_q + GATE_W'(1);
          cnt_d = cnt_next;
          ovf_d = ovf_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // window state registers; reset discards any window in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // result register: a load wins over acceptance; overwriting an unread result is sticky-flagged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_count_q <= cnt_next;
        out_ovf_q   <= ovf_next;
        if (out_valid_q && !out_ready) begin
          dropped_q <= 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign dropped   = dropped_q;

endmodule
